error_tolerant_type2_corrector16: RTL

- Consumer-side companion to the 16-bit error-tolerant type-II adder.
- Accepts the adder's operands and its approximate 17-bit result, then recomputes the exact sum segment by segment with a true rippled carry.
- Reports the exact sum, which segments were wrong, and a running count of erroneous transactions.
- Sits after the approximate datapath for accuracy monitoring and selective recovery.

---
 rtl/error_tolerant_type2_corrector16.sv | 119 +++++++++++
 1 files changed

// File: rtl/error_tolerant_type2_corrector16.sv
// Exact-sum checker for the error-tolerant type-II adder: recomputes A+B one
// segment per cycle with a true rippled carry and flags mismatching segments.
module error_tolerant_type2_corrector16 #(
   parameter int WIDTH = 16,
   parameter int SEG_W = 4,
   parameter int CNT_W = 16,
   localparam int NUM_SEG = WIDTH / SEG_W
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   add1_i,
   input  logic [WIDTH-1:0]   add2_i,
   input  logic [WIDTH:0]     approx_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [WIDTH:0]     exact_o,
   output logic               err_o,
   output logic [NUM_SEG:0]   err_mask_o,
   output logic [CNT_W-1:0]   err_cnt_o,
   input  logic               cnt_clr_i
);

   localparam int SEG_IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       a_q, b_q;
   logic [WIDTH:0]         approx_q;
   logic [WIDTH:0]         exact_q;
   logic [NUM_SEG:0]       mask_q;
   logic [SEG_IDX_W-1:0]   seg_idx_q;
   logic                   carry_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [SEG_W-1:0]       seg_a, seg_b, seg_apx;
   logic [SEG_W:0]         seg_sum;
   logic                   last_seg;
   logic                   accept;
   logic                   out_fire;

   always_comb begin
      seg_a    = a_q[seg_idx_q*SEG_W +: SEG_W];
      seg_b    = b_q[seg_idx_q*SEG_W +: SEG_W];
      seg_apx  = approx_q[seg_idx_q*SEG_W +: SEG_W];
      seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + (SEG_W+1)'(carry_q);
      last_seg = (seg_idx_q == SEG_IDX_W'(NUM_SEG-1));
      accept   = in_valid_i && (state_q == IDLE);
      out_fire = out_ready_i && (state_q == OUT);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (last_seg) state_d = OUT;
         OUT:     if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Results are written segment by segment; they hold untouched in IDLE/OUT.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q       <= '0;
         b_q       <= '0;
         approx_q  <= '0;
         exact_q   <= '0;
         mask_q    <= '0;
         seg_idx_q <= '0;
         carry_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q       <= add1_i;
                  b_q       <= add2_i;
                  approx_q  <= approx_i;
                  seg_idx_q <= '0;
                  carry_q   <= 1'b0;
               end
            end
            SCAN: begin
               exact_q[seg_idx_q*SEG_W +: SEG_W] <= seg_sum[SEG_W-1:0];
               mask_q[seg_idx_q] <= (seg_sum[SEG_W-1:0] != seg_apx);
               carry_q   <= seg_sum[SEG_W];
               seg_idx_q <= seg_idx_q + SEG_IDX_W'(1);
               if (last_seg) begin
                  exact_q[WIDTH]  <= seg_sum[SEG_W];
                  mask_q[NUM_SEG] <= (seg_sum[SEG_W] != approx_q[WIDTH]);
               end
            end
            default: ;
         endcase
      end
   end

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                  cnt_q <= '0;
      else if (cnt_clr_i)                           cnt_q <= '0;
      else if (out_fire && (|mask_q) && !(&cnt_q))  cnt_q <= cnt_q + CNT_W'(1);
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == OUT);
   assign exact_o     = exact_q;
   assign err_mask_o  = mask_q;
   assign err_o       = |mask_q;
   assign err_cnt_o   = cnt_q;

endmodule
